// File: rtl/apb_evt_rmw_master.sv
// apb_evt_rmw_master: APB3 master turning per-channel event pulses into read-modify-write counter increments.
// Define APB_PSLVERR_EN to add pslverr_i / err_o error handling.
module apb_evt_rmw_master #(
  parameter int NUM_EVT = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hABBA_0000,
  parameter int STRIDE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] event_i,
  output logic               psel_o,
  output logic               penable_o,
  output logic [ADDR_W-1:0]  paddr_o,
  output logic               pwrite_o,
  output logic [DATA_W-1:0]  pwdata_o,
  input  logic               pready_i,
  input  logic [DATA_W-1:0]  prdata_i,
`ifdef APB_PSLVERR_EN
  input  logic               pslverr_i,
  output logic [NUM_EVT-1:0] err_o,
`endif
  output logic               busy_o,
  output logic [NUM_EVT-1:0] ovf_o
);
  localparam int PW = NUM_EVT > 1 ? $clog2(NUM_EVT) : 1;
  typedef enum logic [2:0] {IDLE, RD_SETUP, RD_ACCESS, WR_SETUP, WR_ACCESS} state_t;
  state_t state_q, state_d;
  logic [NUM_EVT-1:0][CNT_W-1:0] pend_q, pend_d;
  logic [NUM_EVT-1:0] ovf_d;
  logic [PW-1:0] ptr_q, ptr_d, ch_q, ch_d, gidx;
  logic any, take, slverr;
  logic psel_d, penable_d, pwrite_d, busy_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d;
`ifdef APB_PSLVERR_EN
  assign slverr = pslverr_i;
  always_ff @(posedge clk)
    if (rst) err_o <= '0;
    else if (pready_i && pslverr_i && (state_q == RD_ACCESS || state_q == WR_ACCESS)) err_o[ch_q] <= 1'b1;
`else
  assign slverr = 1'b0;
`endif
  // Round-robin: first pending channel at or above the pointer, else wrap to the lowest.
  always_comb begin
    any = 1'b0;
    gidx = '0;
    for (int i = 0; i < NUM_EVT; i++)
      if (!any && i >= int'(ptr_q) && pend_q[i] != '0) begin
        any = 1'b1;
        gidx = PW'(i);
      end
    for (int i = 0; i < NUM_EVT; i++)
      if (!any && pend_q[i] != '0) begin
        any = 1'b1;
        gidx = PW'(i);
      end
  end
  assign take = (state_q == IDLE) && any;
  always_comb begin
    pend_d = pend_q;
    ovf_d = ovf_o;
    for (int i = 0; i < NUM_EVT; i++)
      if (event_i[i] && !(take && gidx == PW'(i))) begin
        if (&pend_q[i]) ovf_d[i] = 1'b1;
        else pend_d[i] = pend_q[i] + CNT_W'(1);
      end else if (!event_i[i] && take && gidx == PW'(i)) pend_d[i] = pend_q[i] - CNT_W'(1);
  end
  always_comb begin
    state_d = state_q;
    psel_d = psel_o;
    penable_d = penable_o;
    pwrite_d = pwrite_o;
    paddr_d = paddr_o;
    pwdata_d = pwdata_o;
    ch_d = ch_q;
    ptr_d = ptr_q;
    case (state_q)
      IDLE: if (any) begin
        state_d = RD_SETUP;
        psel_d = 1'b1;
        ch_d = gidx;
        paddr_d = BASE_ADDR + ADDR_W'(gidx) * ADDR_W'(STRIDE);
        ptr_d = (gidx == PW'(NUM_EVT - 1)) ? '0 : gidx + PW'(1);
      end
      RD_SETUP: begin
        state_d = RD_ACCESS;
        penable_d = 1'b1;
      end
      RD_ACCESS: if (pready_i) begin
        state_d = slverr ? IDLE : WR_SETUP;
        psel_d = !slverr;
        penable_d = 1'b0;
        pwrite_d = !slverr;
        pwdata_d = slverr ? pwdata_o : prdata_i + DATA_W'(1);
      end
      WR_SETUP: begin
        state_d = WR_ACCESS;
        penable_d = 1'b1;
      end
      WR_ACCESS: if (pready_i) begin
        state_d = IDLE;
        psel_d = 1'b0;
        penable_d = 1'b0;
        pwrite_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      pend_q <= '0;
      ptr_q <= '0;
      ch_q <= '0;
      ovf_o <= '0;
      psel_o <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o <= 1'b0;
      paddr_o <= '0;
      pwdata_o <= '0;
      busy_o <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      ptr_q <= ptr_d;
      ch_q <= ch_d;
      ovf_o <= ovf_d;
      psel_o <= psel_d;
      penable_o <= penable_d;
      pwrite_o <= pwrite_d;
      paddr_o <= paddr_d;
      pwdata_o <= pwdata_d;
      busy_o <= busy_d;
    end
endmodule

// File: tb/tb_apb_evt_rmw_master.sv
// tb_apb_evt_rmw_master: scoreboard bench with an APB slave model, RR vector table and corner-case sequences.
module tb_apb_evt_rmw_master;
  localparam logic [31:0] BASE = 32'hABBA_0000;
  typedef struct {logic [31:0] addr; logic [31:0] data;} exp_t;
  typedef struct {logic [2:0] evt; int rw; int ww; int n; int o0; int o1; int o2;} vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] event_i = '0;
  logic psel_o, penable_o, pwrite_o, busy_o;
  logic pready_i = 1'b0;
  logic [31:0] paddr_o, pwdata_o, prdata_i = '0, off;
  logic [2:0] ovf_o;
`ifdef APB_PSLVERR_EN
  logic pslverr_i = 1'b0;
  logic [2:0] err_o;
`endif
  exp_t sb[$];
  vec_t v[6];
  logic [31:0] mem[3], exp_mem[3];
  int checks = 0, failures = 0, writes = 0, rd_wait = 0, wr_wait = 0, wcnt = 0, ch = 0, w0, k;
  bit sb_off = 1'b0, err_rd = 1'b0;

  always #5 clk = ~clk;

  apb_evt_rmw_master dut (
    .clk(clk), .rst(rst), .event_i(event_i),
    .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pready_i(pready_i), .prdata_i(prdata_i),
`ifdef APB_PSLVERR_EN
    .pslverr_i(pslverr_i), .err_o(err_o),
`endif
    .busy_o(busy_o), .ovf_o(ovf_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int c);
    sb.push_back('{BASE + 32'(c) * 4, exp_mem[c] + 32'd1});
    exp_mem[c] = exp_mem[c] + 32'd1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_psel"}, psel_o, 0);
    chk({nm, "_penable"}, penable_o, 0);
    chk({nm, "_pwrite"}, pwrite_o, 0);
    chk({nm, "_paddr"}, paddr_o, 0);
    chk({nm, "_pwdata"}, pwdata_o, 0);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_ovf"}, ovf_o, 0);
`ifdef APB_PSLVERR_EN
    chk({nm, "_err"}, err_o, 0);
`endif
  endtask

  // APB slave with programmable wait states, plus scoreboard monitor.
  initial forever begin
    @(negedge clk);
    off = paddr_o - BASE;
    ch = (off < 32'd12) ? int'(off >> 2) : 0;
    if (psel_o && !penable_o) wcnt = pwrite_o ? wr_wait : rd_wait;
    if (psel_o && penable_o && wcnt > 0) begin
      pready_i = 1'b0;
      wcnt--;
    end else pready_i = psel_o && penable_o;
    prdata_i = mem[ch];
`ifdef APB_PSLVERR_EN
    pslverr_i = err_rd && !pwrite_o && ch == 2;
`endif
    if (psel_o && !sb_off) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_xfer: got paddr %h expected no transfer", paddr_o);
      end else begin
        chk("mon_paddr", paddr_o, sb[0].addr);
        if (pwrite_o) chk("mon_pwdata", pwdata_o, sb[0].data);
      end
    end
    if (psel_o && penable_o && pready_i && pwrite_o) begin
      mem[ch] = pwdata_o;
      writes++;
      if (!sb_off && sb.size() > 0) void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    mem = '{32'h5, 32'h100, 32'hFFFF_FFFF};
    exp_mem = mem;
    v[0] = '{3'b111, 0, 0, 3, 0, 1, 2};
    v[1] = '{3'b101, 0, 0, 2, 0, 2, 0};
    v[2] = '{3'b010, 3, 2, 1, 1, 0, 0};
    v[3] = '{3'b011, 0, 0, 2, 0, 1, 0};
    v[4] = '{3'b100, 0, 0, 1, 2, 0, 0};
    v[5] = '{3'b110, 1, 1, 2, 1, 2, 0};
    repeat (2) @(negedge clk);
    chk_zero("rst0");
    rst = 1'b0;
    // Single event: read setup two cycles after the event.
    push(0);
    event_i = 3'b001;
    @(negedge clk);
    event_i = '0;
    chk("lat_t1_psel", psel_o, 0);
    @(negedge clk);
    chk("lat_t2_psel", psel_o, 1);
    chk("lat_t2_penable", penable_o, 0);
    chk("lat_t2_pwrite", pwrite_o, 0);
    chk("lat_t2_paddr", paddr_o, BASE);
    chk("lat_t2_busy", busy_o, 1);
    @(negedge clk);
    chk("lat_t3_penable", penable_o, 1);
    @(negedge clk);
    chk("lat_t4_pwrite", pwrite_o, 1);
    chk("lat_t4_penable", penable_o, 0);
    chk("lat_t4_pwdata", pwdata_o, 32'h6);
    @(negedge clk);
    chk("lat_t5_penable", penable_o, 1);
    @(negedge clk);
    chk("lat_t6_busy", busy_o, 0);
    chk("lat_t6_psel", psel_o, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst1");
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 6; r++) begin
      w0 = writes;
      rd_wait = v[r].rw;
      wr_wait = v[r].ww;
      if (v[r].n > 0) push(v[r].o0);
      if (v[r].n > 1) push(v[r].o1);
      if (v[r].n > 2) push(v[r].o2);
      event_i = v[r].evt;
      @(negedge clk);
      event_i = '0;
      drain(200);
      chk($sformatf("row%0d_writes", r), writes - w0, v[r].n);
      chk($sformatf("row%0d_ovf", r), ovf_o, 0);
    end
    rd_wait = 0;
    wr_wait = 0;
    // Pending-count saturation while the bus is stalled.
    w0 = writes;
    rd_wait = 30;
    for (int i = 0; i < 16; i++) push(1);
    for (int i = 0; i < 17; i++) begin
      event_i = 3'b010;
      @(negedge clk);
      if (i == 15) chk("ovf_early", ovf_o, 0);
    end
    event_i = '0;
    chk("ovf_set", ovf_o, 3'b010);
    rd_wait = 0;
    drain(2000);
    repeat (10) @(negedge clk);
    chk("ovf_writes", writes - w0, 16);
    chk("ovf_sticky", ovf_o, 3'b010);
    // Reset in WR_SETUP with one more event still pending.
    sb_off = 1'b1;
    w0 = writes;
    event_i = 3'b100;
    repeat (2) @(negedge clk);
    event_i = '0;
    k = 0;
    while (!(psel_o && pwrite_o && !penable_o) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("wr_setup_reached", k < 20, 1);
    chk("wr_setup_wrap_pwdata", pwdata_o, exp_mem[2] + 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid");
    rst = 1'b0;
    k = 0;
    repeat (12) begin
      @(negedge clk);
      if (psel_o) k++;
    end
    chk("rst_mid_no_pend", k, 0);
    chk("rst_mid_no_write", writes - w0, 0);
    sb_off = 1'b0;
`ifdef APB_PSLVERR_EN
    sb_off = 1'b1;
    err_rd = 1'b1;
    w0 = writes;
    event_i = 3'b100;
    @(negedge clk);
    event_i = '0;
    repeat (8) @(negedge clk);
    chk("slverr_err", err_o, 3'b100);
    chk("slverr_no_write", writes - w0, 0);
    chk("slverr_idle", busy_o, 0);
    err_rd = 1'b0;
    sb_off = 1'b0;
`endif
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
